// File: rtl/tc_misr_sig_if.sv
// rtl/tc_misr_sig_if.sv - compaction session bus between BIST sequencer and tc_misr_sig
interface tc_misr_sig_if #(
  parameter int WIDTH = 16,
  parameter int MW    = 8,
  parameter int CNT_W = 8
);
  logic             START;
  logic [CNT_W-1:0] LEN;
  logic [WIDTH-1:0] GOLD;
  logic             M_EN;
  logic [MW-1:0]    M;
  logic             BUSY;
  logic             DONE;
  logic             PASS;

  modport master (output START, LEN, GOLD, M_EN, M, input BUSY, DONE, PASS);
  modport slave  (input START, LEN, GOLD, M_EN, M, output BUSY, DONE, PASS);
endinterface

// File: rtl/tc_misr_sig.sv
// rtl/tc_misr_sig.sv - MISR with seed load, scan shift and counted signature compaction
module tc_misr_sig #(
  parameter int             WIDTH = 16,
  parameter int             MW    = 8,
  parameter logic [WIDTH-1:0] TAPS = 16'h6801,
  parameter int             CNT_W = 8
) (
  input  logic             phi,
  input  logic             RST_N,
  input  logic             SET_EN,
  input  logic [WIDTH-1:0] SET_VAL,
  input  logic             SI_EN,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] OUT,
  tc_misr_sig_if.slave     sess
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] gold_q;
  logic [WIDTH-1:0] misr_next;
  logic             ctl;
  logic             step;
  logic             start_ok;

  always_comb begin
    state_d   = state_q;
    ctl       = SET_EN | SI_EN;
    step      = 1'b0;
    start_ok  = 1'b0;
    sess.BUSY = (state_q == COMPACT);
    sess.DONE = (state_q == DONE);
    sess.PASS = (state_q == DONE) && (OUT == gold_q);
    // Shift toward the MSB, fold the MSB back through TAPS, inject responses at the low stages.
    misr_next = {OUT[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{OUT[WIDTH-1]}}) ^ WIDTH'(sess.M);

    if (ctl) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (sess.START) begin
            start_ok = 1'b1;
            state_d  = (sess.LEN != '0) ? COMPACT : DONE;
          end
        end
        COMPACT: begin
          if (sess.M_EN) begin
            step = 1'b1;
            if (count_q == CNT_W'(1)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      OUT     <= '0;
      count_q <= '0;
      gold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (SET_EN)      OUT <= SET_VAL;
      else if (SI_EN)  OUT <= {OUT[WIDTH-2:0], SI};
      else if (step)   OUT <= misr_next;

      if (start_ok) begin
        count_q <= sess.LEN;
        gold_q  <= sess.GOLD;
      end else if (step) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign SO = OUT[WIDTH-1];

endmodule

// File: tb/tb_tc_misr_sig.sv
// tb/tb_tc_misr_sig.sv - directed vector bench for tc_misr_sig
module tb_tc_misr_sig;

  logic        phi = 1'b0;
  logic        RST_N;
  logic        SET_EN;
  logic [15:0] SET_VAL;
  logic        SI_EN;
  logic        SI;
  logic        SO;
  logic [15:0] OUT;

  tc_misr_sig_if #(.WIDTH(16), .MW(8), .CNT_W(8)) sess ();

  tc_misr_sig #(.WIDTH(16), .MW(8), .TAPS(16'h6801), .CNT_W(8)) dut (
    .phi     (phi),
    .RST_N   (RST_N),
    .SET_EN  (SET_EN),
    .SET_VAL (SET_VAL),
    .SI_EN   (SI_EN),
    .SI      (SI),
    .SO      (SO),
    .OUT     (OUT),
    .sess    (sess)
  );

  always #5 phi = ~phi;

  typedef struct {
    logic        set_en;
    logic [15:0] set_val;
    logic        si_en;
    logic        si;
    logic        start;
    logic [7:0]  len;
    logic [15:0] gold;
    logic        m_en;
    logic [7:0]  m;
    logic [15:0] e_out;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic set_en, input logic [15:0] set_val, input logic si_en, input logic si,
                     input logic start, input logic [7:0] len, input logic [15:0] gold,
                     input logic m_en, input logic [7:0] m,
                     input logic [15:0] e_out, input logic e_busy, input logic e_done, input logic e_pass);
    vec_t v;
    v.set_en = set_en; v.set_val = set_val; v.si_en = si_en; v.si = si;
    v.start = start; v.len = len; v.gold = gold; v.m_en = m_en; v.m = m;
    v.e_out = e_out; v.e_busy = e_busy; v.e_done = e_done; v.e_pass = e_pass;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic set_en, input logic [15:0] set_val, input logic si_en, input logic si,
                       input logic start, input logic [7:0] len, input logic [15:0] gold,
                       input logic m_en, input logic [7:0] m);
    SET_EN = set_en; SET_VAL = set_val; SI_EN = si_en; SI = si;
    sess.START = start; sess.LEN = len; sess.GOLD = gold; sess.M_EN = m_en; sess.M = m;
  endtask

  // Bit-by-bit reference of one compaction step.
  function automatic logic [15:0] ref_step(input logic [15:0] cur, input logic [7:0] m);
    logic [15:0] taps;
    logic [15:0] nx;
    taps = 16'h6801;
    for (int i = 0; i < 16; i++) begin
      nx[i] = ((i == 0) ? 1'b0 : cur[i-1]) ^ (taps[i] & cur[15]) ^ ((i < 8) ? m[i] : 1'b0);
    end
    return nx;
  endfunction

  task automatic check_flags(input string tag, input logic [15:0] e_out, input logic b, input logic d, input logic p);
    chk({tag, " out"},  32'(OUT), 32'(e_out));
    chk({tag, " so"},   32'(SO), 32'(e_out[15]));
    chk({tag, " busy"}, 32'(sess.BUSY), 32'(b));
    chk({tag, " done"}, 32'(sess.DONE), 32'(d));
    chk({tag, " pass"}, 32'(sess.PASS), 32'(p));
  endtask

  initial begin
    logic [15:0] model;
    logic [7:0]  mr;

    RST_N = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 8'd0, 16'h0, 0, 8'h0);
    repeat (2) @(posedge phi);
    #1;
    check_flags("reset", 16'h0000, 0, 0, 0);
    @(negedge phi);
    RST_N = 1'b1;

    // set/en  val     si si st len  gold     me m      out      b  d  p
    add(1, 16'h1234, 0, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'h1234, 0, 0, 0);
    add(1, 16'h0000, 0, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'h0000, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      add(0, 16'h0, 1, 1, 0, 8'd0, 16'h0, 0, 8'h00, 16'((32'd1 << k) - 1), 0, 0, 0);
    add(0, 16'h0,    1, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'hFFFE, 0, 0, 0);
    add(0, 16'h0,    1, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'hFFFC, 0, 0, 0);
    add(0, 16'h0,    1, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'hFFF8, 0, 0, 0);
    add(0, 16'h0,    1, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'hFFF0, 0, 0, 0);
    // LEN=3 passing session
    add(1, 16'h8000, 0, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'h8000, 0, 0, 0);
    add(0, 16'h0,    0, 0, 1, 8'd3, 16'hC805, 1, 8'h00, 16'h8000, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'h6801, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'hD002, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'hC805, 0, 1, 1);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'hC805, 0, 1, 1);
    // same session, wrong golden
    add(1, 16'h8000, 0, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'h8000, 0, 0, 0);
    add(0, 16'h0,    0, 0, 1, 8'd3, 16'hC804, 1, 8'h00, 16'h8000, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'h6801, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'hD002, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'hC805, 0, 1, 0);
    // stalled LEN=1 session
    add(1, 16'h0000, 0, 0, 0, 8'd0, 16'h0,    0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 16'h0,    0, 0, 1, 8'd1, 16'h0001, 0, 8'h01, 16'h0000, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    0, 8'h01, 16'h0000, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    0, 8'h01, 16'h0000, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h01, 16'h0001, 0, 1, 1);
    // LEN=0 restarts straight from DONE, new golden each time
    add(0, 16'h0,    0, 0, 1, 8'd0, 16'h0002, 1, 8'hFF, 16'h0001, 0, 1, 0);
    add(0, 16'h0,    0, 0, 1, 8'd0, 16'h0001, 1, 8'hFF, 16'h0001, 0, 1, 1);
    // START with SET_EN: load wins, session not started
    add(1, 16'h5A5A, 0, 0, 1, 8'd3, 16'h5A5A, 1, 8'h00, 16'h5A5A, 0, 0, 0);
    add(0, 16'h0,    0, 0, 0, 8'd0, 16'h0,    1, 8'h00, 16'h5A5A, 0, 0, 0);
    // START inside COMPACT must not reload LEN or GOLD
    add(0, 16'h0,    0, 0, 1, 8'd2, 16'h0169, 0, 8'h00, 16'h5A5A, 1, 0, 0);
    add(0, 16'h0,    0, 0, 1, 8'd5, 16'hFFFF, 1, 8'h00, 16'hB4B4, 1, 0, 0);
    add(0, 16'h0,    0, 0, 1, 8'd5, 16'hFFFF, 1, 8'h00, 16'h0169, 0, 1, 1);
    // scan shift in DONE aborts the session
    add(0, 16'h0,    1, 1, 0, 8'd0, 16'h0,    1, 8'h00, 16'h02D3, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].set_en, vecs[i].set_val, vecs[i].si_en, vecs[i].si, vecs[i].start,
            vecs[i].len, vecs[i].gold, vecs[i].m_en, vecs[i].m);
      @(posedge phi);
      #1;
      check_flags($sformatf("v%0d", i), vecs[i].e_out, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_pass);
      @(negedge phi);
    end

    // LEN=20 with random responses, aborted by SET_EN on the fifth step
    drive(1, 16'h1111, 0, 0, 0, 8'd0, 16'h0, 0, 8'h00);
    @(posedge phi); @(negedge phi);
    model = 16'h1111;
    drive(0, 16'h0, 0, 0, 1, 8'd20, 16'h0, 0, 8'h00);
    @(posedge phi); #1;
    check_flags("abort start", model, 1, 0, 0);
    @(negedge phi);
    for (int s = 1; s <= 4; s++) begin
      mr = 8'($urandom_range(0, 255));
      drive(0, 16'h0, 0, 0, 0, 8'd0, 16'h0, 1, mr);
      model = ref_step(model, mr);
      @(posedge phi); #1;
      check_flags($sformatf("abort step%0d", s), model, 1, 0, 0);
      @(negedge phi);
    end
    drive(1, 16'hABCD, 0, 0, 0, 8'd0, 16'h0, 1, 8'h5A);
    @(posedge phi); #1;
    check_flags("abort set", 16'hABCD, 0, 0, 0);
    @(negedge phi);

    // second run, asynchronous reset in the middle
    model = 16'hABCD;
    drive(0, 16'h0, 0, 0, 1, 8'd20, 16'h0, 1, 8'h00);
    @(posedge phi); @(negedge phi);
    for (int s = 1; s <= 3; s++) begin
      mr = 8'($urandom_range(0, 255));
      drive(0, 16'h0, 0, 0, 0, 8'd0, 16'h0, 1, mr);
      model = ref_step(model, mr);
      @(posedge phi); #1;
      check_flags($sformatf("rst step%0d", s), model, 1, 0, 0);
      @(negedge phi);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_flags("async rst", 16'h0000, 0, 0, 0);
    @(negedge phi);
    RST_N = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 8'd0, 16'h0, 1, 8'hFF);
    @(posedge phi); #1;
    check_flags("post rst", 16'h0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tc_misr_sig.md
Name: tc_misr_sig

Overview:
- Parametrised multiple-input signature register (MISR) with a built-in signature-compaction controller for BIST response analysis in the tc_lib test-compression path.
- Width, input-port width and feedback polynomial are configurable; seed load and serial scan in/out are retained.
- Adds counted compaction sessions (START/LEN), a stall input (M_EN), a captured golden signature and DONE/PASS reporting.

Parameters:
- WIDTH, 16, signature register width (>= 2).
- MW, 8, parallel response input width (1..WIDTH); M[i] feeds stage i.
- TAPS, 16'h6801, feedback mask (WIDTH bits): bit i set means stage i receives OUT[WIDTH-1]. Bit 0 must be set for a proper MISR.
- CNT_W, 8, compaction length counter width.

Ports:
- phi  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- SET_EN  in  1  synchronous parallel load of SET_VAL.
- SET_VAL  in  WIDTH  seed value.
- SI_EN  in  1  scan-shift enable.
- SI  in  1  scan serial input.
- SO  out  1  scan serial output = OUT[WIDTH-1].
- START  in  1  begin compaction session.
- LEN  in  CNT_W  number of compaction cycles; sampled with START.
- GOLD  in  WIDTH  expected signature; sampled with START.
- M_EN  in  1  compaction qualifier; low stalls the session.
- M  in  MW  parallel response data.
- OUT  out  WIDTH  signature register.
- BUSY  out  1  high in COMPACT.
- DONE  out  1  high in DONE.
- PASS  out  1  DONE and (OUT == captured GOLD).

Behaviour:
- Reset (RST_N low, asynchronous): OUT=0, count=0, gold_q=0, state IDLE. BUSY, DONE, PASS and SO are 0.
- Register update priority per edge: SET_EN > SI_EN > compaction step > hold.
  - SET_EN: OUT <= SET_VAL.
  - SI_EN: OUT <= {OUT[WIDTH-2:0], SI}.
- Compaction step (state COMPACT and M_EN=1): next[i] = (i==0 ? 0 : OUT[i-1]) ^ (TAPS[i] & OUT[WIDTH-1]) ^ (i<MW ? M[i] : 0).
- The register never compacts outside COMPACT. In IDLE and DONE it holds unless SET_EN or SI_EN is asserted.
- States are IDLE, COMPACT and DONE.
  - IDLE: START (with SET_EN=SI_EN=0) captures count<=LEN and gold_q<=GOLD. Goes to COMPACT if LEN!=0, otherwise directly to DONE.
  - COMPACT: each M_EN=1 cycle performs one step and count<=count-1. When a step occurs with count==1, go to DONE on the same edge. M_EN=0 holds count and OUT. START is ignored.
  - DONE: holds. START (with SET_EN=SI_EN=0) restarts exactly as from IDLE, with no intervening IDLE cycle.
- SET_EN or SI_EN asserted in COMPACT or DONE performs its load/shift and forces IDLE (session aborted, DONE/PASS drop next cycle). START asserted together with SET_EN or SI_EN is ignored.
- Latency: DONE rises on the edge of the LEN-th qualified step. PASS is valid in the same cycle as DONE. OUT is stable throughout DONE.
- The counter never wraps: LEN=0 means zero steps, not 2^CNT_W.
- Reset mid-session returns to IDLE immediately and clears everything.

Test Plan:
- Reset, then SET_EN=1 with SET_VAL=16'h1234 for 1 cycle -> OUT=16'h1234; BUSY=DONE=PASS=0.
- SET_VAL=0 load, then SI_EN=1 with SI=1 for 16 cycles -> OUT=16'hFFFF; SO=1 from cycle 16. Then SI=0 for 4 cycles -> OUT=16'hFFF0.
- Seed 16'h8000, START with LEN=3, GOLD=16'hC805, M=0, M_EN=1 -> OUT goes 6801, D002, C805; BUSY for 3 cycles; DONE=PASS=1. Repeat with GOLD=16'hC804 -> DONE=1, PASS=0.
- Seed 0, START with LEN=1, GOLD=16'h0001, M=8'h01 with M_EN low for 2 cycles, then high -> OUT holds 0 while stalled; OUT=16'h0001, DONE=PASS=1 one cycle after M_EN rises.
- START with LEN=0, GOLD=current OUT -> DONE=PASS=1 next cycle, OUT unchanged. Then START together with SET_EN -> load performed, START ignored, state IDLE.
- START with LEN=20 and random M; at step 5 assert SET_EN -> IDLE, OUT=SET_VAL, BUSY=0. In a second run, pulse RST_N low mid-session -> OUT=0 and all flags 0 immediately (asynchronous).
